// File: rtl/tone_pkg.sv
// tone_pkg: shared FSM state type and limits for the tone/PWM generator
package tone_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int P_MIN = 2;
  localparam int CNT_W_DEF = 13;
endpackage

// File: rtl/tone_period_counter.sv
// tone_period_counter: cycle counter with period wrap, tick and glitch-free P/H shadow apply
module tone_period_counter import tone_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_xfer,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [CNT_W-1:0] p,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] h_n,
  output logic             period_tick,
  output logic             pending,
  output logic             shrink
);
  logic [CNT_W-1:0] cnt, h, p_sh, h_sh;
  logic apply, load;
  // next count and next high-time; a pending config lands at period end, or at once when idle
  always_comb begin
    period_tick = run && cnt == p - CNT_W'(1);
    apply = pending && (period_tick || !run);
    load = cfg_xfer && !run;
    shrink = period_tick && pending && p_sh < CNT_W'(P_MIN);
    cnt_n = (period_tick || !run) ? '0 : cnt + CNT_W'(1);
    h_n = apply ? h_sh : (load ? cfg_high : h);
  end
  // counter, active and shadow settings
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      p <= '0;
      h <= '0;
      p_sh <= '0;
      h_sh <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= cnt_n;
      p <= apply ? p_sh : (load ? cfg_period : p);
      h <= h_n;
      if (cfg_xfer && run) begin
        p_sh <= cfg_period;
        h_sh <= cfg_high;
      end
      pending <= (cfg_xfer && run) || (pending && !apply);
    end
  end
endmodule

// File: rtl/tone_pwm_gen.sv
// tone_pwm_gen: programmable square/PWM tone with valid/ready config; TONE_BURST_EN adds burst playback
module tone_pwm_gen import tone_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
`ifdef TONE_BURST_EN
  , parameter int BURST_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             enable,
  output logic             tone_out,
  output logic             period_tick,
  output logic             active
`ifdef TONE_BURST_EN
  , input  logic [BURST_W-1:0] burst_len,
  output logic               burst_done
`endif
);
  state_t state, state_n;
  logic run, xfer, pending, shrink, start_ok, burst_end;
  logic [CNT_W-1:0] p, cnt_n, h_n;
  assign run = state != IDLE;
  assign active = run;
  assign cfg_ready = !pending;
  assign xfer = cfg_valid && cfg_ready;
  tone_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .run(run),
    .cfg_xfer(xfer),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .p(p),
    .cnt_n(cnt_n),
    .h_n(h_n),
    .period_tick(period_tick),
    .pending(pending),
    .shrink(shrink)
  );
`ifdef TONE_BURST_EN
  logic [BURST_W-1:0] bcnt;
  logic armed;
  assign burst_end = period_tick && bcnt == BURST_W'(1);
  assign start_ok = armed;
  // burst down-counter; after a burst, enable must be seen low before a restart
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      armed <= 1'b1;
      burst_done <= 1'b0;
    end else begin
      bcnt <= (!run && state_n == RUN) ? burst_len : ((period_tick && bcnt != '0) ? bcnt - BURST_W'(1) : bcnt);
      armed <= !enable || (armed && !burst_end);
      burst_done <= burst_end;
    end
  end
`else
  assign burst_end = 1'b0;
  assign start_ok = 1'b1;
`endif
  // next state: start needs a usable period, stopping always finishes the current period
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (enable && start_ok && p >= CNT_W'(P_MIN) && !(xfer && cfg_period < CNT_W'(P_MIN))) state_n = RUN;
      RUN: state_n = (burst_end || shrink) ? IDLE : (enable ? RUN : STOP);
      STOP: state_n = (burst_end || shrink || (period_tick && !enable)) ? IDLE : (enable ? RUN : STOP);
      default: state_n = IDLE;
    endcase
  end
  // state register and tone flop driven from the next-cycle compare
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tone_out <= 1'b0;
    end else begin
      state <= state_n;
      tone_out <= state_n != IDLE && cnt_n < h_n;
    end
  end
endmodule

// File: tb/tb_tone_pwm_gen.sv
// tb_tone_pwm_gen: scoreboard bench for tone_pwm_gen with directed per-cycle expectations
module tb_tone_pwm_gen;
  localparam int CNT_W = 13;
  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, enable, tone_out, period_tick, active;
  logic [CNT_W-1:0] cfg_period, cfg_high;
`ifdef TONE_BURST_EN
  logic [7:0] burst_len;
  logic burst_done;
`endif
  typedef struct {
    string nm;
    logic [4:0] e;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tone_pwm_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .enable(enable),
    .tone_out(tone_out),
    .period_tick(period_tick),
    .active(active)
`ifdef TONE_BURST_EN
    , .burst_len(burst_len),
    .burst_done(burst_done)
`endif
  );

  function automatic logic [4:0] ev(input bit t, input bit k, input bit a, input bit r, input bit b = 1'b0);
    return {t, k, a, r, b};
  endfunction

  task automatic cyc(input string nm, input logic [4:0] e);
    sb.push_back('{nm, e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t x;
        logic [4:0] act;
        x = sb.pop_front();
`ifdef TONE_BURST_EN
        act = {tone_out, period_tick, active, cfg_ready, burst_done};
`else
        act = {tone_out, period_tick, active, cfg_ready, 1'b0};
`endif
        n_checks++;
        if (act !== x.e) begin
          n_fail++;
          $display("FAIL %s @%0t: tone/tick/active/ready/bdone got %b expected %b", x.nm, $time, act, x.e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_period = '0;
    cfg_high = '0;
    enable = 1'b0;
`ifdef TONE_BURST_EN
    burst_len = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cfg_valid = 1'b1;
    cfg_period = 10;
    cfg_high = 5;
    cyc("reset", ev(0, 0, 0, 1));
    cfg_valid = 1'b0;
    enable = 1'b1;
    cyc("idle_before_run", ev(0, 0, 0, 1));
    for (int i = 0; i < 20; i++) cyc("run_p10", ev(i % 10 < 5, i % 10 == 9, 1, 1));
    for (int i = 0; i < 10; i++) begin
      cfg_valid = i == 3;
      cfg_period = 20;
      cfg_high = 2;
      cyc("reconfig_p10", ev(i < 5, i == 9, 1, i <= 3));
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 20; i++) cyc("switch_p20", ev(i < 2, i == 19, 1, 1));
    for (int i = 0; i < 20; i++) begin
      enable = !(i >= 3 && i < 6);
      cyc("reraise", ev(i < 2, i == 19, 1, 1));
    end
    for (int i = 0; i < 20; i++) begin
      enable = i < 3;
      cyc("stop", ev(i < 2, i == 19, 1, 1));
    end
    cyc("stopped_idle", ev(0, 0, 0, 1));
    cfg_valid = 1'b1;
    cfg_period = 20;
    cfg_high = 0;
    cyc("idle_cfg_h0", ev(0, 0, 0, 1));
    cfg_valid = 1'b0;
    enable = 1'b1;
    cyc("idle_start_h0", ev(0, 0, 0, 1));
    for (int i = 0; i < 20; i++) begin
      cfg_valid = i == 5;
      cfg_period = 20;
      cfg_high = 25;
      cyc("h0", ev(0, i == 19, 1, i <= 5));
    end
    for (int i = 0; i < 20; i++) begin
      cfg_valid = i == 0;
      cfg_period = 1;
      cfg_high = 0;
      cyc("h25", ev(1, i == 19, 1, i == 0));
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc("p1_idle", ev(0, 0, 0, 1));
    enable = 1'b0;
    cfg_valid = 1'b1;
    cfg_period = 10;
    cfg_high = 5;
    cyc("idle_cfg_rst", ev(0, 0, 0, 1));
    cfg_valid = 1'b0;
    enable = 1'b1;
    cyc("idle_start_rst", ev(0, 0, 0, 1));
    for (int i = 0; i < 5; i++) begin
      cfg_valid = i == 2;
      cfg_period = 20;
      cfg_high = 2;
      rst = i == 4;
      cyc("pre_rst", ev(1, 0, 1, i <= 2));
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc("post_rst", ev(0, 0, 0, 1));
`ifdef TONE_BURST_EN
    enable = 1'b0;
    cfg_valid = 1'b1;
    cfg_period = 4;
    cfg_high = 2;
    burst_len = 3;
    cyc("idle_cfg_burst", ev(0, 0, 0, 1));
    cfg_valid = 1'b0;
    enable = 1'b1;
    cyc("idle_start_burst", ev(0, 0, 0, 1));
    for (int i = 0; i < 12; i++) cyc("burst3", ev(i % 4 < 2, i % 4 == 3, 1, 1));
    cyc("burst_done", ev(0, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++) cyc("burst_hold", ev(0, 0, 0, 1));
    enable = 1'b0;
    burst_len = 0;
    cyc("burst_rearm", ev(0, 0, 0, 1));
    enable = 1'b1;
    cyc("burst_unl_start", ev(0, 0, 0, 1));
    for (int i = 0; i < 20; i++) cyc("burst_unl", ev(i % 4 < 2, i % 4 == 3, 1, 1));
`endif
    enable = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
